// File: rtl/mem_stage_sram_ctrl.sv
// Memory stage: 32-bit word loads/stores over a 16-bit SRAM,
// split into low/high half-word phases with programmable wait states.
module mem_stage_sram_ctrl #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned ADDR_BASE   = 1024,
   parameter int unsigned SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_dq_oe,
   output logic               sram_we_n,
   output logic               sram_oe_n
);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

   state_e             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               wr_q, wr_d;
   logic [SRAM_AW-2:0] widx_q, widx_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [31:0]        offs;
   logic               req;
   logic               last;
   logic               unused_offs;

   assign req  = mem_read | mem_write;
   assign offs = address - 32'(ADDR_BASE);
   assign last = (cnt_q == 4'(WAIT_CYCLES));
   assign read_data = rdata_q;

   // Byte offset bits and high bits beyond the SRAM window are dropped.
   assign unused_offs = ^{offs[1:0], offs[31:SRAM_AW+1]};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_d        = wr_q;
      widx_d      = widx_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      ready       = 1'b0;
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;
      sram_oe_n   = 1'b1;
      unique case (state_q)
         IDLE: begin
            ready = ~req;
            if (req) begin
               wr_d    = mem_write;
               widx_d  = offs[SRAM_AW:2];
               wdata_d = write_data;
               cnt_d   = '0;
               state_d = LO;
            end
         end
         LO: begin
            sram_addr = {widx_q, 1'b0};
            if (wr_q) begin
               sram_dq_oe  = 1'b1;
               sram_dq_out = wdata_q[15:0];
               sram_we_n   = ~last;
            end else begin
               sram_oe_n = 1'b0;
               if (last) rdata_d[15:0] = sram_dq_in;
            end
            if (last) begin
               cnt_d   = '0;
               state_d = HI;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         HI: begin
            sram_addr = {widx_q, 1'b1};
            if (wr_q) begin
               sram_dq_oe  = 1'b1;
               sram_dq_out = wdata_q[31:16];
               sram_we_n   = ~last;
            end else begin
               sram_oe_n = 1'b0;
               if (last) rdata_d[31:16] = sram_dq_in;
            end
            if (last) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE: begin
            ready   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         widx_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         widx_q  <= widx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench: two controllers (WAIT_CYCLES=1 and 0)
// sharing one half-word SRAM model.
module tb_mem_stage_sram_ctrl;

   localparam int AW   = 18;
   localparam int MAXC = 40;

   logic          clk, rst, sel;
   logic          mem_read, mem_write;
   logic [31:0]   address, write_data;
   logic          rd0, wr0, rd1, wr1;
   logic [31:0]   rdata0, rdata1;
   logic          rdy0, rdy1;
   logic [AW-1:0] a0, a1;
   logic [15:0]   dqo0, dqo1, dqi0, dqi1;
   logic          dqoe0, dqoe1, wen0, wen1, oen0, oen1;
   logic [15:0]   mem [0:(1<<AW)-1];

   logic          o_rdy, o_wen, o_oen, o_dqoe;
   logic [31:0]   o_rd, o_addr, o_dqo;

   bit [31:0] r_addr [0:MAXC-1];
   bit [31:0] r_dqo  [0:MAXC-1];
   bit [31:0] r_rd   [0:MAXC-1];
   bit        r_wen  [0:MAXC-1];
   bit        r_oen  [0:MAXC-1];
   bit        r_dqoe [0:MAXC-1];
   int        r_cyc  [0:MAXC-1];

   int checks, errors, cyc, nlow, ncyc, t_done;

   assign rd0 = mem_read & ~sel;
   assign wr0 = mem_write & ~sel;
   assign rd1 = mem_read & sel;
   assign wr1 = mem_write & sel;

   mem_stage_sram_ctrl #(.WAIT_CYCLES(1)) u0 (
      .clk(clk), .rst(rst),
      .mem_read(rd0), .mem_write(wr0),
      .address(address), .write_data(write_data),
      .read_data(rdata0), .ready(rdy0),
      .sram_addr(a0), .sram_dq_out(dqo0),
      .sram_dq_in(dqi0), .sram_dq_oe(dqoe0),
      .sram_we_n(wen0), .sram_oe_n(oen0)
   );

   mem_stage_sram_ctrl #(.WAIT_CYCLES(0)) u1 (
      .clk(clk), .rst(rst),
      .mem_read(rd1), .mem_write(wr1),
      .address(address), .write_data(write_data),
      .read_data(rdata1), .ready(rdy1),
      .sram_addr(a1), .sram_dq_out(dqo1),
      .sram_dq_in(dqi1), .sram_dq_oe(dqoe1),
      .sram_we_n(wen1), .sram_oe_n(oen1)
   );

   assign dqi0 = oen0 ? 16'h0 : mem[a0];
   assign dqi1 = oen1 ? 16'h0 : mem[a1];

   always @(posedge clk) begin
      if (!wen0 && dqoe0) mem[a0] <= dqo0;
      if (!wen1 && dqoe1) mem[a1] <= dqo1;
      cyc <= cyc + 1;
   end

   assign o_rdy  = sel ? rdy1   : rdy0;
   assign o_rd   = sel ? rdata1 : rdata0;
   assign o_addr = sel ? 32'(a1) : 32'(a0);
   assign o_dqo  = sel ? 32'(dqo1) : 32'(dqo0);
   assign o_wen  = sel ? wen1   : wen0;
   assign o_oen  = sel ? oen1   : oen0;
   assign o_dqoe = sel ? dqoe1  : dqoe0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic access(input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit drop, input bit keep);
      int  k;
      bit  done;
      @(negedge clk);
      mem_read   = rd;
      mem_write  = wr;
      address    = a;
      write_data = wd;
      #1;
      k    = 0;
      done = 0;
      nlow = 0;
      while (!done && k < MAXC) begin
         r_addr[k] = o_addr;
         r_dqo[k]  = o_dqo;
         r_rd[k]   = o_rd;
         r_wen[k]  = o_wen;
         r_oen[k]  = o_oen;
         r_dqoe[k] = o_dqoe;
         r_cyc[k]  = cyc;
         if (!o_rdy) nlow++;
         else if (k > 0) done = 1;
         if (drop && k == 1) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
         end
         k++;
         if (!done) @(negedge clk);
      end
      ncyc = k;
      if (!done) chk("timeout", 32'd0, 32'd1);
      if (!keep) begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc = 0;
      rst = 1'b0;
      sel = 1'b0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      address = '0;
      write_data = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(o_rdy), 32'd1);
      chk("rst_rdata", o_rd, 32'd0);
      chk("rst_addr", o_addr, 32'd0);
      chk("rst_strobes", {o_wen, o_oen, o_dqoe}, 3'b110);
      chk("rst_dqo", o_dqo, 32'd0);
      chk("rst_rdata1", rdata1, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_ready", 32'(o_rdy), 32'd1);

      access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 0, 0);
      chk("st_low", nlow, 32'd5);
      chk("st_addr", {r_addr[1][3:0], r_addr[2][3:0],
                      r_addr[3][3:0], r_addr[4][3:0]}, 16'h2233);
      chk("st_dq_lo", r_dqo[2], 32'hBEEF);
      chk("st_dq_hi", r_dqo[4], 32'hDEAD);
      chk("st_we", {r_wen[1], r_wen[2], r_wen[3], r_wen[4]}, 4'b1010);
      chk("st_dqoe", {r_dqoe[1], r_dqoe[2], r_dqoe[3], r_dqoe[4]}, 4'b1111);
      chk("st_oen", {r_oen[0], r_oen[1], r_oen[2],
                     r_oen[3], r_oen[4], r_oen[5]}, 6'b111111);
      chk("st_done", {r_wen[5], r_dqoe[5]}, 2'b10);
      chk("st_mem", {mem[3], mem[2]}, 32'hDEADBEEF);

      access(1'b1, 1'b0, 32'd1028, 32'h0, 0, 0);
      chk("ld_low", nlow, 32'd5);
      chk("ld_half", r_rd[3], 32'h0000BEEF);
      chk("ld_data", r_rd[5], 32'hDEADBEEF);
      chk("ld_oen", {r_oen[0], r_oen[1], r_oen[2],
                     r_oen[3], r_oen[4], r_oen[5]}, 6'b100001);
      chk("ld_dqoe", {r_dqoe[1], r_dqoe[2], r_dqoe[3], r_dqoe[4]}, 4'b0000);

      access(1'b0, 1'b1, 32'd1036, 32'h0BADF00D, 0, 0);
      chk("st_keep_rd", r_rd[5], 32'hDEADBEEF);
      chk("st2_mem", {mem[7], mem[6]}, 32'h0BADF00D);

      access(1'b1, 1'b1, 32'd1032, 32'h12345678, 0, 0);
      chk("rw_rd", r_rd[5], 32'hDEADBEEF);
      chk("rw_mem", {mem[5], mem[4]}, 32'h12345678);
      chk("rw_strobe", {r_oen[2], r_wen[2]}, 2'b10);

      access(1'b0, 1'b1, 32'd1020, 32'hCAFE1234, 0, 0);
      chk("wrap_lo", r_addr[1], 32'h3FFFE);
      chk("wrap_hi", r_addr[3], 32'h3FFFF);
      chk("wrap_mem", {mem[18'h3FFFF], mem[18'h3FFFE]}, 32'hCAFE1234);

      access(1'b1, 1'b0, 32'd1028, 32'h0, 0, 1);
      chk("b2b_1", r_rd[5], 32'hDEADBEEF);
      t_done = r_cyc[ncyc-1];
      access(1'b1, 1'b0, 32'd1032, 32'h0, 0, 0);
      chk("b2b_gap", r_cyc[1] - t_done, 32'd2);
      chk("b2b_2", r_rd[5], 32'h12345678);

      access(1'b1, 1'b0, 32'd1028, 32'h0, 1, 0);
      chk("drop_low", nlow, 32'd5);
      chk("drop_oen", 32'(r_oen[3]), 32'd0);
      chk("drop_rd", r_rd[5], 32'hDEADBEEF);

      @(negedge clk);
      mem_write  = 1'b1;
      address    = 32'd1028;
      write_data = 32'h11112222;
      @(negedge clk);
      chk("mid_lo", {o_dqoe, o_wen}, 2'b11);
      rst = 1'b0;
      mem_write = 1'b0;
      #1;
      chk("mid_rst_str", {o_wen, o_dqoe, o_oen}, 3'b101);
      chk("mid_rst_rd", o_rd, 32'd0);
      chk("mid_rst_adr", o_addr, 32'd0);
      chk("mid_rst_rdy", 32'(o_rdy), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rel_ready", 32'(o_rdy), 32'd1);
      chk("rel_mem", {mem[3], mem[2]}, 32'hDEADBEEF);

      sel = 1'b1;
      access(1'b0, 1'b1, 32'd1024, 32'h3C3CA5A5, 0, 0);
      chk("w0_st_low", nlow, 32'd3);
      chk("w0_st_we", {r_wen[1], r_wen[2]}, 2'b00);
      chk("w0_st_mem", {mem[1], mem[0]}, 32'h3C3CA5A5);
      access(1'b1, 1'b0, 32'd1024, 32'h0, 0, 0);
      chk("w0_ld_low", nlow, 32'd3);
      chk("w0_ld_addr", {r_addr[1][3:0], r_addr[2][3:0]}, 8'h01);
      chk("w0_ld_data", r_rd[3], 32'h3C3CA5A5);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Memory-side counterpart of the execute stage.
- Consumes the execute stage's memory request (mem_read/mem_write, ALU-computed address, store data from Rm) and performs 32-bit word accesses on a 16-bit external SRAM as two half-word transfers with programmable wait states.
- Returns load data to writeback.
- Drives `ready` low while busy so the pipeline freezes upstream stages until the access completes.

Parameters:
- WAIT_CYCLES, 1, extra cycles each half-word phase is held (phase length = WAIT_CYCLES+1); legal range 0..15.
- ADDR_BASE, 1024, byte address mapped to SRAM half-word 0.
- SRAM_AW, 18, SRAM half-word address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_read  in  1  load request (held stable while ready=0).
- mem_write  in  1  store request (held stable while ready=0).
- address  in  32  byte address from ALU result.
- write_data  in  32  store data (Rm value).
- read_data  out  32  load result.
- ready  out  1  1 = no access pending / access finishing this cycle; 0 = freeze pipeline.
- sram_addr  out  SRAM_AW  half-word address.
- sram_dq_out  out  16  write data to SRAM.
- sram_dq_in  in  16  read data from SRAM.
- sram_dq_oe  out  1  1 = controller drives DQ.
- sram_we_n  out  1  active-low write strobe.
- sram_oe_n  out  1  active-low output enable.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - state=IDLE, phase counter=0.
  - read_data=0, sram_addr=0, sram_dq_out=0.
  - sram_dq_oe=0, sram_we_n=1, sram_oe_n=1.
- Reset asserted mid-access aborts the access immediately; no partial read_data update survives.
- States: IDLE, LO, HI, DONE.
- `ready` is combinational:
  - 1 in IDLE with no request, 1 in DONE.
  - 0 in IDLE with a request, 0 in LO and HI.
- IDLE with mem_read|mem_write=1:
  - latch the request type, word index = (address - ADDR_BASE) >> 2 (32-bit subtraction, then truncation), and write_data.
  - clear the counter and go to LO.
  - address[1:0] is ignored (word accesses only).
- If both mem_read and mem_write are 1, the access is a write; read_data is unchanged.
- LO phase:
  - sram_addr = {word_index, 1'b0} truncated to SRAM_AW; out-of-range addresses wrap modulo 2^SRAM_AW.
  - Lasts WAIT_CYCLES+1 cycles, then goes to HI.
- HI phase:
  - sram_addr = {word_index, 1'b1}.
  - Lasts WAIT_CYCLES+1 cycles, then goes to DONE.
- Phase counter: counts 0..WAIT_CYCLES within each phase and is cleared on each phase entry.
- Write phases:
  - sram_dq_oe=1 for the whole phase; sram_dq_out = latched data[15:0] in LO and [31:16] in HI.
  - sram_we_n=0 only on the final cycle of each phase; sram_oe_n=1 throughout.
- Read phases:
  - sram_oe_n=0 and sram_dq_oe=0 throughout.
  - On the final cycle of LO, register sram_dq_in into read_data[15:0]; on the final cycle of HI, into read_data[31:16].
  - read_data is otherwise held, and keeps its last load value through stores and idle cycles.
- DONE:
  - One cycle with ready=1; SRAM strobes deasserted (we_n=1, oe_n=1, dq_oe=0).
  - Unconditionally returns to IDLE; a new request is sampled only in IDLE.
- Request inputs are latched at IDLE→LO. Deasserting them mid-access does not cancel the access.
- Latency per access: ready low for 1 + 2*(WAIT_CYCLES+1) cycles, then high for the DONE cycle.
  - WAIT_CYCLES=1: ready low 5 cycles.
  - WAIT_CYCLES=0: ready low 3 cycles.
- Back-to-back requests: IDLE→LO again on the cycle after DONE if a request is present. The minimum gap is DONE plus one IDLE cycle.
- No request: the block stays in IDLE, ready=1, all SRAM strobes inactive.

Test Plan:
- Reset: hold rst=0 mid-LO of a write → immediately sram_we_n=1, sram_dq_oe=0, read_data=0, state IDLE. Release rst → ready=1.
- Store, WAIT_CYCLES=1: mem_write=1, address=1028, write_data=0xDEADBEEF →
  - ready=0 for 5 cycles;
  - sram_addr=2 with dq_out=0xBEEF, then sram_addr=3 with dq_out=0xDEAD;
  - one we_n=0 pulse per phase, on the phase's 2nd cycle;
  - ready=1 on cycle 6.
- Load: SRAM model returns 0xBEEF at half-word 2 and 0xDEAD at 3; mem_read=1, address=1028 → read_data=0xDEADBEEF when ready=1, sram_oe_n=0 only during LO/HI. read_data unchanged after a subsequent store.
- WAIT_CYCLES=0: load at address 1024 → ready low exactly 3 cycles; sram_addr sequence 0, 1.
- Simultaneous mem_read=mem_write=1: address=1032, write_data=0x12345678 → write to half-words 4/5; read_data keeps its prior value.
- Boundary/wrap and back-to-back:
  - address=ADDR_BASE-4 → sram_addr wraps to 2^18-2 then 2^18-1.
  - Two consecutive loads → second access starts the cycle after DONE.
  - Dropping mem_read during LO still completes the access.
